// File: rtl/pu_ia_ic_nway_pkg.sv
// pu_ia_ic_nway_pkg: shared defaults, FSM encodings and way-width helper for the N-way icache
package pu_ia_ic_nway_pkg;
   localparam int PU_IC_WAYS    = 2;
   localparam int PU_IC_INDEX_W = 6;
   localparam int PU_IC_TAG_W   = 20;
   localparam int PU_IC_DATA_W  = 32;
   localparam logic [0:0] PU_IC_ST_IDLE  = 1'b0;
   localparam logic [0:0] PU_IC_ST_SWEEP = 1'b1;
   function automatic int way_w(input int ways);
      return ways > 1 ? $clog2(ways) : 1;
   endfunction
endpackage

// File: rtl/pu_ia_ic_way.sv
// pu_ia_ic_way: one way of tag/valid/data storage; optional parity under PU_IC_PARITY_EN
module pu_ia_ic_way #(
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 20,
   parameter int DATA_W  = 32
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  we,
   input  logic [INDEX_W-1:0]    wr_index,
   input  logic [TAG_W-1:0]      wr_ptag,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2**INDEX_W-1:0] clr,
   input  logic [INDEX_W-1:0]    rd_index,
   input  logic [TAG_W-1:0]      rd_ptag,
   output logic                  rd_match,
   output logic                  rd_perr,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  wr_match,
   output logic                  wr_valid,
   input  logic [INDEX_W-1:0]    inv_index,
   input  logic [TAG_W-1:0]      inv_ptag,
   output logic                  inv_match
);
   localparam int SETS = 2**INDEX_W;
   logic [SETS-1:0]   valid;
   logic [TAG_W-1:0]  tag [SETS];
   logic [DATA_W-1:0] data [SETS];
   // a fill in the same cycle as a clear of the same set wins
   always_ff @(posedge clk)
      if (!rst_) valid <= '0;
      else valid <= (valid & ~clr) | (SETS'(we) << wr_index);
   always_ff @(posedge clk)
      if (we) begin
         tag[wr_index]  <= wr_ptag;
         data[wr_index] <= wr_data;
      end
   assign rd_match  = valid[rd_index] && tag[rd_index] == rd_ptag;
   assign rd_data   = data[rd_index];
   assign wr_match  = valid[wr_index] && tag[wr_index] == wr_ptag;
   assign wr_valid  = valid[wr_index];
   assign inv_match = valid[inv_index] && tag[inv_index] == inv_ptag;
`ifdef PU_IC_PARITY_EN
   logic par [SETS];
   always_ff @(posedge clk)
      if (we) par[wr_index] <= ^{wr_ptag, wr_data};
   assign rd_perr = rd_match && (par[rd_index] != ^{tag[rd_index], data[rd_index]});
`else
   assign rd_perr = 1'b0;
`endif
endmodule

// File: rtl/pu_ia_ic_nway.sv
// pu_ia_ic_nway: N-way set-associative icache array with RR fill, invalidate and sweep; PU_IC_PARITY_EN adds parity
module pu_ia_ic_nway import pu_ia_ic_nway_pkg::*; #(
   parameter int WAYS    = PU_IC_WAYS,
   parameter int INDEX_W = PU_IC_INDEX_W,
   parameter int TAG_W   = PU_IC_TAG_W,
   parameter int DATA_W  = PU_IC_DATA_W,
   localparam int WW     = way_w(WAYS)
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic               on,
   input  logic               rd_req,
   input  logic [INDEX_W-1:0] rd_index,
   input  logic [TAG_W-1:0]   rd_ptag,
   output logic               rd_hit,
   output logic [WW-1:0]      rd_way,
   output logic [DATA_W-1:0]  rd_data,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_ptag,
   input  logic [DATA_W-1:0]  wr_data,
   input  logic               inv_en,
   input  logic [INDEX_W-1:0] inv_index,
   input  logic [TAG_W-1:0]   inv_ptag,
   input  logic               inv_all,
   output logic               busy
);
   localparam int SETS = 2**INDEX_W;
   logic [0:0]         st;
   logic [INDEX_W-1:0] cnt;
   logic [WAYS-1:0]    rm, perr, wm, wv, im, hv;
   logic [DATA_W-1:0]  rdat [WAYS];
   logic [WW-1:0]      vic, psel, way_n, lo, mt;
   logic [DATA_W-1:0]  dat_n;
   logic               adv, lk, fill_ok, inv_ok, sweep;
   assign sweep   = rst_ && st == PU_IC_ST_SWEEP;
   assign lk      = rst_ && rd_req && on && !busy;
   // a fill landing on the set being swept this cycle is dropped so the sweep leaves it clear
   assign fill_ok = rst_ && wr_en && on && !busy && !(sweep && wr_index == cnt);
   assign inv_ok  = rst_ && inv_en && !busy;
   assign hv      = rm & ~perr;
   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic [SETS-1:0] clr;
      assign clr = ({SETS{sweep}} & (SETS'(1) << cnt))
                 | ({SETS{inv_ok && im[w]}} & (SETS'(1) << inv_index))
                 | ({SETS{lk && perr[w]}} & (SETS'(1) << rd_index));
      pu_ia_ic_way #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way (
         .clk, .rst_, .we(fill_ok && vic == WW'(w)), .wr_index, .wr_ptag, .wr_data, .clr,
         .rd_index, .rd_ptag, .rd_match(rm[w]), .rd_perr(perr[w]), .rd_data(rdat[w]),
         .wr_match(wm[w]), .wr_valid(wv[w]), .inv_index, .inv_ptag, .inv_match(im[w])
      );
   end
   always_comb begin
      lo = '0;
      mt = '0;
      way_n = '0;
      dat_n = '0;
      for (int i = WAYS - 1; i >= 0; i--) lo = !wv[i] ? WW'(i) : lo;
      for (int i = 0; i < WAYS; i++) mt = wm[i] ? WW'(i) : mt;
      for (int i = 0; i < WAYS; i++) begin
         way_n = hv[i] ? way_n | WW'(i) : way_n;
         dat_n = hv[i] ? dat_n | rdat[i] : dat_n;
      end
      vic = |wm ? mt : !(&wv) ? lo : psel;
      adv = fill_ok && &wv && !(|wm);
   end
   if (WAYS > 1) begin : g_rr
      logic [WW-1:0] ptr [SETS];
      assign psel = ptr[wr_index];
      always_ff @(posedge clk)
         if (!rst_) for (int i = 0; i < SETS; i++) ptr[i] <= '0;
         else if (adv) ptr[wr_index] <= ptr[wr_index] + 1'b1;
   end else begin : g_rr
      assign psel = '0;
   end
   always_ff @(posedge clk)
      if (!rst_) begin
         st      <= PU_IC_ST_SWEEP;
         cnt     <= '0;
         busy    <= 1'b0;
         rd_hit  <= 1'b0;
         rd_way  <= '0;
         rd_data <= '0;
      end else begin
         busy    <= st == PU_IC_ST_SWEEP;
         rd_hit  <= lk && |hv;
         rd_way  <= lk ? way_n : '0;
         rd_data <= lk ? dat_n : '0;
         if (st == PU_IC_ST_SWEEP) begin
            cnt <= cnt + 1'b1;
            if (&cnt) st <= PU_IC_ST_IDLE;
         end else if (inv_all) begin
            st  <= PU_IC_ST_SWEEP;
            cnt <= '0;
         end
      end
endmodule

// File: tb/tb_pu_ia_ic_nway.sv
// tb_pu_ia_ic_nway: directed bench with a set-level behavioural cache model compared every cycle
module tb_pu_ia_ic_nway;
   localparam int WAYS = 2, IW = 6, TW = 20, DW = 32, SETS = 64;
   logic clk = 0, rst_ = 0, on = 0, rd_req = 0, wr_en = 0, inv_en = 0, inv_all = 0;
   logic [IW-1:0] rd_index = 0, wr_index = 0, inv_index = 0;
   logic [TW-1:0] rd_ptag = 0, wr_ptag = 0, inv_ptag = 0;
   logic [DW-1:0] wr_data = 0;
   logic          rd_hit, busy;
   logic [0:0]    rd_way;
   logic [DW-1:0] rd_data;
   int ncmp = 0, nerr = 0;

   always #5 clk = ~clk;

   pu_ia_ic_nway #(.WAYS(WAYS), .INDEX_W(IW), .TAG_W(TW), .DATA_W(DW)) dut (
      .clk(clk), .rst_(rst_), .on(on), .rd_req(rd_req), .rd_index(rd_index), .rd_ptag(rd_ptag),
      .rd_hit(rd_hit), .rd_way(rd_way), .rd_data(rd_data), .wr_en(wr_en), .wr_index(wr_index),
      .wr_ptag(wr_ptag), .wr_data(wr_data), .inv_en(inv_en), .inv_index(inv_index),
      .inv_ptag(inv_ptag), .inv_all(inv_all), .busy(busy)
   );

   // model state: per-way per-set lines, per-set replacement pointer, sweep progress
   bit            mv   [WAYS][SETS];
   logic [TW-1:0] mt   [WAYS][SETS];
   logic [DW-1:0] md   [WAYS][SETS];
   bit            mcor [WAYS][SETS];
   int            mp   [SETS];
   bit            in_sw, mbusy, started = 0;
   int            sc;
   logic          e_hit = 0, e_busy = 0;
   logic [0:0]    e_way = 0;
   logic [DW-1:0] e_dat = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int fw, iw, hw;
      if (!rst_) begin
         for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
               mv[w][s] = 0;
               mcor[w][s] = 0;
            end
         for (int s = 0; s < SETS; s++) mp[s] = 0;
         in_sw = 1; sc = 0; mbusy = 0;
         e_hit = 0; e_way = 0; e_dat = 0; e_busy = 0;
      end else begin
         e_hit = 0; e_way = 0; e_dat = 0;
         fw = -1; iw = -1; hw = -1;
         if (rd_req && on && !mbusy)
            for (int w = 0; w < WAYS; w++)
               if (mv[w][rd_index] && mt[w][rd_index] == rd_ptag) begin
                  if (mcor[w][rd_index]) hw = w;
                  else begin
                     e_hit = 1; e_way = 1'(w); e_dat = md[w][rd_index];
                  end
               end
         if (inv_en && !mbusy)
            for (int w = 0; w < WAYS; w++)
               if (mv[w][inv_index] && mt[w][inv_index] == inv_ptag) iw = w;
         if (wr_en && on && !mbusy) begin
            for (int w = WAYS - 1; w >= 0; w--) if (!mv[w][wr_index]) fw = w;
            for (int w = 0; w < WAYS; w++)
               if (mv[w][wr_index] && mt[w][wr_index] == wr_ptag) fw = w;
            if (fw < 0) begin
               fw = mp[wr_index];
               mp[wr_index] = (mp[wr_index] + 1) % WAYS;
            end
         end
         if (iw >= 0) mv[iw][inv_index] = 0;
         if (hw >= 0) mv[hw][rd_index] = 0;
         if (fw >= 0) begin
            mv[fw][wr_index] = 1; mt[fw][wr_index] = wr_ptag;
            md[fw][wr_index] = wr_data; mcor[fw][wr_index] = 0;
         end
         e_busy = in_sw;
         if (in_sw) begin
            for (int w = 0; w < WAYS; w++) mv[w][sc] = 0;
            sc++;
            if (sc == SETS) in_sw = 0;
         end else if (inv_all) begin
            in_sw = 1; sc = 0;
         end
         mbusy = e_busy;
      end
      started = 1;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (started) begin
         chk("rd_hit", rd_hit, e_hit);
         chk("rd_way", rd_way, e_way);
         chk("rd_data", rd_data, e_dat);
         chk("busy", busy, e_busy);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      rd_req = 0; wr_en = 0; inv_en = 0; inv_all = 0;
   endtask

   task automatic look(input logic [IW-1:0] i, input logic [TW-1:0] t);
      rd_index = i; rd_ptag = t; rd_req = 1;
      tick();
   endtask

   task automatic fill(input logic [IW-1:0] i, input logic [TW-1:0] t, input logic [DW-1:0] d);
      wr_index = i; wr_ptag = t; wr_data = d; wr_en = 1;
      tick();
   endtask

   task automatic count_busy(output int n, input bit do_fill);
      n = 0;
      for (int k = 0; k < 200; k++) begin
         if (n == 10) begin rd_index = 5; rd_ptag = 0; rd_req = 1; end
         if (do_fill && n == 5) begin wr_index = 20; wr_ptag = 'h777; wr_data = 'h77; wr_en = 1; end
         tick();
         if (busy) n++;
         else if (n > 0 || k > 2) break;
         if (n == 11) chk("sweep_look_miss", rd_hit, 0);
      end
   endtask

   initial begin
      int n;
      on = 1;
      repeat (3) tick();
      chk("rst_hit", rd_hit, 0);
      chk("rst_busy", busy, 0);
      rst_ = 1;
      count_busy(n, 0);
      chk("reset_sweep_len", n, 64);
      for (int i = 0; i < 8; i++) begin
         look(IW'(i * 9), TW'(i * 3));
         chk("post_sweep_miss", rd_hit, 0);
      end
      fill(3, 'h12345, 'hDEADBEEF);
      look(3, 'h12345);
      chk("hit3", rd_hit, 1); chk("way3", rd_way, 0); chk("data3", rd_data, 'hDEADBEEF);
      look(3, 'h12346);
      chk("miss3_hit", rd_hit, 0); chk("miss3_data", rd_data, 0);
      fill(7, 'h00A0A, 'hA); fill(7, 'h00B0B, 'hB); fill(7, 'h00C0C, 'hC);
      look(7, 'h00A0A); chk("rr_a_evicted", rd_hit, 0);
      look(7, 'h00B0B); chk("rr_b_hit", rd_hit, 1); chk("rr_b_way", rd_way, 1);
      look(7, 'h00C0C); chk("rr_c_way", rd_way, 0); chk("rr_c_data", rd_data, 'hC);
      fill(7, 'h00D0D, 'hD);
      look(7, 'h00D0D); chk("rr_d_way", rd_way, 1); chk("rr_d_data", rd_data, 'hD);
      look(7, 'h00B0B); chk("rr_b_evicted", rd_hit, 0);
      fill(3, 'h12345, 'h0BADF00D);
      look(3, 'h12345);
      chk("refill_data", rd_data, 'h0BADF00D); chk("refill_way", rd_way, 0);
      fill(9, 'hABC, 'h1111);
      wr_index = 9; wr_ptag = 'hABC; wr_data = 'h2222; wr_en = 1;
      inv_index = 9; inv_ptag = 'hABC; inv_en = 1;
      tick();
      look(9, 'hABC);
      chk("fill_wins_hit", rd_hit, 1); chk("fill_wins_data", rd_data, 'h2222);
      inv_index = 9; inv_ptag = 'hABC; inv_en = 1;
      tick();
      look(9, 'hABC); chk("inv_miss", rd_hit, 0);
      inv_all = 1;
      tick();
      count_busy(n, 1);
      chk("inv_all_sweep_len", n, 64);
      look(20, 'h777); chk("busy_fill_dropped", rd_hit, 0);
      look(3, 'h12345); chk("swept_line", rd_hit, 0);
      on = 0;
      fill(30, 'h555, 'h55);
      look(30, 'h555); chk("off_miss", rd_hit, 0);
      on = 1;
      look(30, 'h555); chk("off_fill_dropped", rd_hit, 0);
`ifdef PU_IC_PARITY_EN
      fill(40, 'h999, 'h1234);
      look(40, 'h999); chk("par_clean_hit", rd_hit, 1);
      dut.g_way[0].u_way.data[40] = dut.g_way[0].u_way.data[40] ^ 32'h1;
      mcor[0][40] = 1;
      look(40, 'h999); chk("par_err_miss", rd_hit, 0);
      look(40, 'h999); chk("par_healed_miss", rd_hit, 0);
`endif
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
